// File: rtl/resp_md_chan_arbiter.sv
// Per-lane metadata buffers merged into one downstream FIFO by a round-robin arbiter
// that stays locked on a lane until the group's LAST entry has been forwarded.
module resp_md_chan_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 192,
    parameter int DEPTH  = 4,
    parameter int PF_TH  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_CH-1:0]        iv_md_wr_en,
    input  logic [NUM_CH*DATA_W-1:0] iv_md_data,
    output logic [NUM_CH-1:0]        ov_md_prog_full,
    input  logic                     i_out_prog_full,
    output logic                     o_out_wr_en,
    output logic [DATA_W-1:0]        ov_out_data,
    output logic [2:0]               ov_out_ch,
    input  logic [NUM_CH-1:0]        iv_init_finish,
    output logic                     o_init_finish,
    input  logic [31:0]              dbg_sel,
    output logic [31:0]              dbg_bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LANE_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    logic [DATA_W-1:0] mem       [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  wr_ptr    [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr    [NUM_CH];
    logic [CNT_W-1:0]  count     [NUM_CH];
    logic [CNT_W-1:0]  count_nxt [NUM_CH];
    logic [15:0]       pop_cnt   [NUM_CH];
    logic [NUM_CH-1:0] ovf;
    logic [NUM_CH-1:0] push_acc;
    logic [NUM_CH-1:0] pop_sel;

    state_t            state;
    logic [LANE_W-1:0] lock_lane;
    logic [LANE_W-1:0] last_grant;
    logic [LANE_W-1:0] cand;

    logic              vld_p0;
    logic [LANE_W-1:0] lane_p0;
    logic [DATA_W-1:0] head_p0;

    // p0: pop decision and head read
    always_comb begin
        vld_p0  = 1'b0;
        lane_p0 = '0;
        cand    = '0;
        if (!i_out_prog_full) begin
            if (state == LOCKED) begin
                if (count[lock_lane] != '0) begin
                    vld_p0  = 1'b1;
                    lane_p0 = lock_lane;
                end
            end else begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    cand = LANE_W'((int'(last_grant) + i) % NUM_CH);
                    if (!vld_p0 && count[cand] != '0) begin
                        vld_p0  = 1'b1;
                        lane_p0 = cand;
                    end
                end
            end
        end
    end

    assign head_p0 = mem[lane_p0][rd_ptr[lane_p0]];

    // A full lane still accepts a push in the cycle it is being popped.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            pop_sel[k]   = vld_p0 && (lane_p0 == LANE_W'(k));
            push_acc[k]  = iv_md_wr_en[k] && ((count[k] != CNT_W'(DEPTH)) || pop_sel[k]);
            count_nxt[k] = count[k] + CNT_W'(push_acc[k]) - CNT_W'(pop_sel[k]);
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (push_acc[k])
                mem[k][wr_ptr[k]] <= iv_md_data[k*DATA_W +: DATA_W];
        end
    end

    // p1: registered output stage and lane bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                wr_ptr[k]  <= '0;
                rd_ptr[k]  <= '0;
                count[k]   <= '0;
                pop_cnt[k] <= '0;
            end
            ovf             <= '0;
            ov_md_prog_full <= '0;
            state           <= IDLE;
            lock_lane       <= '0;
            last_grant      <= LANE_W'(NUM_CH - 1);
            o_out_wr_en     <= 1'b0;
            ov_out_data     <= '0;
            ov_out_ch       <= '0;
            o_init_finish   <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (push_acc[k])
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                if (pop_sel[k]) begin
                    rd_ptr[k]  <= rd_ptr[k] + 1'b1;
                    pop_cnt[k] <= pop_cnt[k] + 16'd1;
                end
                if (iv_md_wr_en[k] && !push_acc[k])
                    ovf[k] <= 1'b1;
                count[k]           <= count_nxt[k];
                ov_md_prog_full[k] <= (count_nxt[k] >= CNT_W'(PF_TH));
            end

            if (vld_p0) begin
                if (state == IDLE) begin
                    last_grant <= lane_p0;
                    if (!head_p0[DATA_W-1]) begin
                        state     <= LOCKED;
                        lock_lane <= lane_p0;
                    end
                end else if (head_p0[DATA_W-1]) begin
                    state <= IDLE;
                end
                ov_out_data <= head_p0;
                ov_out_ch   <= 3'(lane_p0);
            end
            o_out_wr_en   <= vld_p0;
            o_init_finish <= &iv_init_finish;
        end
    end

    always_comb begin
        dbg_bus = '0;
        if (dbg_sel == 32'd0)
            dbg_bus = {state, 3'(lock_lane), 3'(last_grant), 25'b0};
        for (int k = 0; k < NUM_CH; k++) begin
            if (dbg_sel == 32'(k + 1))
                dbg_bus = {ovf[k], ov_md_prog_full[k], 14'b0, pop_cnt[k]};
        end
    end
endmodule

// File: tb/tb_resp_md_chan_arbiter.sv
// Bench for resp_md_chan_arbiter: directed corner sequences, an init-finish vector
// table and a randomized run against a queue-based reference model.
module tb_resp_md_chan_arbiter;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 192;
    localparam int DEPTH  = 4;
    localparam int PF_TH  = 3;

    typedef logic [DATA_W-1:0] dat_t;
    typedef struct packed {
        logic [NUM_CH-1:0] init;
        logic              exp;
    } ivec_t;

    logic                     clk;
    logic                     rst_n;
    logic [NUM_CH-1:0]        iv_md_wr_en;
    logic [NUM_CH*DATA_W-1:0] iv_md_data;
    logic [NUM_CH-1:0]        ov_md_prog_full;
    logic                     i_out_prog_full;
    logic                     o_out_wr_en;
    logic [DATA_W-1:0]        ov_out_data;
    logic [2:0]               ov_out_ch;
    logic [NUM_CH-1:0]        iv_init_finish;
    logic                     o_init_finish;
    logic [31:0]              dbg_sel;
    logic [31:0]              dbg_bus;

    resp_md_chan_arbiter #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH), .PF_TH(PF_TH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .iv_md_wr_en(iv_md_wr_en),
        .iv_md_data(iv_md_data),
        .ov_md_prog_full(ov_md_prog_full),
        .i_out_prog_full(i_out_prog_full),
        .o_out_wr_en(o_out_wr_en),
        .ov_out_data(ov_out_data),
        .ov_out_ch(ov_out_ch),
        .iv_init_finish(iv_init_finish),
        .o_init_finish(o_init_finish),
        .dbg_sel(dbg_sel),
        .dbg_bus(dbg_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    dat_t              q [NUM_CH][$];
    int                m_lock;
    int                m_lock_lane;
    int                m_last;
    bit                m_ovf [NUM_CH];
    int                m_popcnt [NUM_CH];
    bit                e_wr;
    dat_t              e_data;
    int                e_ch;
    logic [NUM_CH-1:0] e_pf;
    bit                e_init;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) begin
            q[k].delete();
            m_ovf[k]    = 1'b0;
            m_popcnt[k] = 0;
        end
        m_lock      = -1;
        m_lock_lane = 0;
        m_last      = NUM_CH - 1;
        e_wr        = 1'b0;
        e_data      = '0;
        e_ch        = 0;
        e_pf        = '0;
        e_init      = 1'b0;
    endtask

    // Applies the arbitration rules to the inputs present just before a clock edge.
    task automatic model_edge();
        int   pl;
        int   sz [NUM_CH];
        dat_t h;
        pl = -1;
        for (int k = 0; k < NUM_CH; k++) sz[k] = q[k].size();
        if (!i_out_prog_full) begin
            if (m_lock >= 0) begin
                if (sz[m_lock] > 0) pl = m_lock;
            end else begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    int c;
                    c = (m_last + i) % NUM_CH;
                    if (pl < 0 && sz[c] > 0) pl = c;
                end
            end
        end
        e_wr = (pl >= 0);
        if (pl >= 0) begin
            h = q[pl].pop_front();
            e_data = h;
            e_ch   = pl;
            m_popcnt[pl] = (m_popcnt[pl] + 1) % 65536;
            if (m_lock < 0) begin
                m_last = pl;
                if (!h[DATA_W-1]) begin
                    m_lock      = pl;
                    m_lock_lane = pl;
                end
            end else if (h[DATA_W-1]) begin
                m_lock = -1;
            end
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (iv_md_wr_en[k]) begin
                if (sz[k] < DEPTH || pl == k) q[k].push_back(iv_md_data[k*DATA_W +: DATA_W]);
                else m_ovf[k] = 1'b1;
            end
            e_pf[k] = (q[k].size() >= PF_TH);
        end
        e_init = &iv_init_finish;
    endtask

    function automatic logic [31:0] model_dbg(input logic [31:0] sel);
        logic [31:0] r;
        r = '0;
        if (sel == 0)
            r = {1'(m_lock >= 0), 3'(m_lock_lane), 3'(m_last), 25'b0};
        else if (sel <= NUM_CH)
            r = {m_ovf[sel-1], e_pf[sel-1], 14'b0, 16'(m_popcnt[sel-1])};
        return r;
    endfunction

    task automatic check_all();
        chk("out_wr_en", o_out_wr_en, e_wr);
        chk("out_data", ov_out_data, e_data);
        chk("out_ch", ov_out_ch, e_ch);
        chk("prog_full", ov_md_prog_full, e_pf);
        chk("init_finish", o_init_finish, e_init);
        chk("dbg_bus", dbg_bus, model_dbg(dbg_sel));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic set_push(input int k, input bit last);
        dat_t d;
        for (int w = 0; w < DATA_W / 32; w++) d[w*32 +: 32] = $urandom;
        d[DATA_W-1] = last;
        iv_md_wr_en[k] = 1'b1;
        iv_md_data[k*DATA_W +: DATA_W] = d;
    endtask

    task automatic clear_push();
        iv_md_wr_en = '0;
    endtask

    task automatic do_reset();
        rst_n           = 1'b0;
        iv_md_wr_en     = '0;
        i_out_prog_full = 1'b0;
        iv_init_finish  = '0;
        dbg_sel         = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset_dbg0", dbg_bus, 32'h0600_0000);
        rst_n = 1'b1;
    endtask

    ivec_t tbl [6];
    int    got_ch  [$];
    int    got_cyc [$];
    int    n_out;

    initial begin
        rst_n           = 1'b0;
        iv_md_wr_en     = '0;
        iv_md_data      = '0;
        i_out_prog_full = 1'b0;
        iv_init_finish  = '0;
        dbg_sel         = '0;
        model_reset();

        tbl[0] = '{init: 4'b0111, exp: 1'b0};
        tbl[1] = '{init: 4'b1111, exp: 1'b1};
        tbl[2] = '{init: 4'b1110, exp: 1'b0};
        tbl[3] = '{init: 4'b1111, exp: 1'b1};
        tbl[4] = '{init: 4'b0000, exp: 1'b0};
        tbl[5] = '{init: 4'b1011, exp: 1'b0};

        // Two single-entry groups: lane 0 then lane 2
        do_reset();
        set_push(0, 1'b1);
        set_push(2, 1'b1);
        step();
        clear_push();
        chk("t1_c1_idle", o_out_wr_en, 1'b0);
        step();
        chk("t1_c2_wr", o_out_wr_en, 1'b1);
        chk("t1_c2_ch", ov_out_ch, 3'd0);
        step();
        chk("t1_c3_wr", o_out_wr_en, 1'b1);
        chk("t1_c3_ch", ov_out_ch, 3'd2);
        step();
        chk("t1_c4_idle", o_out_wr_en, 1'b0);

        // Locked three-entry group on lane 1 ahead of lane 3
        do_reset();
        got_ch.delete();
        got_cyc.delete();
        set_push(1, 1'b0);
        set_push(3, 1'b1);
        for (int c = 0; c < 9; c++) begin
            if (c == 1) set_push(1, 1'b0);
            if (c == 2) set_push(1, 1'b1);
            step();
            clear_push();
            if (o_out_wr_en) begin
                got_ch.push_back(int'(ov_out_ch));
                got_cyc.push_back(c);
            end
        end
        chk("t2_count", got_ch.size(), 4);
        if (got_ch.size() == 4) begin
            chk("t2_ch0", got_ch[0], 1);
            chk("t2_ch1", got_ch[1], 1);
            chk("t2_ch2", got_ch[2], 1);
            chk("t2_ch3", got_ch[3], 3);
            chk("t2_consecutive", got_cyc[3] - got_cyc[0], 3);
        end

        // Overflow while downstream is full
        do_reset();
        i_out_prog_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_push(0, 1'b1);
            step();
            if (i == 1) chk("t3_pf_after2", ov_md_prog_full[0], 1'b0);
            if (i == 2) chk("t3_pf_after3", ov_md_prog_full[0], 1'b1);
        end
        clear_push();
        chk("t3_no_out_while_full", o_out_wr_en, 1'b0);
        dbg_sel = 32'd1;
        #1;
        chk("t3_ovf", dbg_bus[31], 1'b1);
        chk("t3_pf_dbg", dbg_bus[30], 1'b1);
        i_out_prog_full = 1'b0;
        n_out = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_out_wr_en) n_out++;
        end
        chk("t3_out_count", n_out, 4);
        chk("t3_popcnt", dbg_bus[15:0], 16'd4);
        chk("t3_ovf_sticky", dbg_bus[31], 1'b1);
        dbg_sel = 32'd0;

        // Saturated round-robin
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_push(k, 1'b1);
        step();
        for (int i = 0; i < 12; i++) begin
            for (int k = 0; k < NUM_CH; k++) set_push(k, 1'b1);
            step();
            chk("t4_wr", o_out_wr_en, 1'b1);
            chk("t4_ch", ov_out_ch, 3'(i % NUM_CH));
        end
        clear_push();

        // Async reset in the middle of a locked group
        do_reset();
        iv_init_finish  = '1;
        i_out_prog_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_push(2, 1'b0);
            step();
        end
        clear_push();
        i_out_prog_full = 1'b0;
        step();
        chk("t5_locked", dbg_bus[31], 1'b1);
        chk("t5_out_before", o_out_wr_en, 1'b1);
        #4;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("t5_rst_wr", o_out_wr_en, 1'b0);
        chk("t5_rst_data", ov_out_data, '0);
        chk("t5_rst_ch", ov_out_ch, 3'd0);
        chk("t5_rst_pf", ov_md_prog_full, '0);
        chk("t5_rst_init", o_init_finish, 1'b0);
        chk("t5_rst_dbg", dbg_bus, 32'h0600_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t5_no_stale", o_out_wr_en, 1'b0);
        end
        chk("t5_idle", dbg_bus[31], 1'b0);

        // init_finish vector table
        for (int i = 0; i < 6; i++) begin
            iv_init_finish = tbl[i].init;
            step();
            chk("t6_init", o_init_finish, tbl[i].exp);
        end

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if ($urandom_range(0, 2) == 0) set_push(k, 1'($urandom_range(0, 1)));
                else iv_md_wr_en[k] = 1'b0;
            end
            i_out_prog_full = ($urandom_range(0, 4) == 0);
            iv_init_finish  = ($urandom_range(0, 3) == 0) ? '1 : NUM_CH'($urandom);
            dbg_sel         = $urandom_range(0, NUM_CH + 2);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
